// File: rtl/cam_cmd_arbiter_if.sv
// Camera register-access channel bundle: two requester ports and the
// engine-facing command/response pair. The arbiter uses the slave modport.
interface cam_cmd_arbiter_if;
    logic [16:0] host_cmd;
    logic        host_cmd_valid;
    logic        host_cmd_ready;
    logic [17:0] host_resp;
    logic        host_resp_valid;

    logic [16:0] init_cmd;
    logic        init_cmd_valid;
    logic        init_cmd_ready;
    logic [17:0] init_resp;
    logic        init_resp_valid;

    logic [16:0] rw_cmd;
    logic        rw_cmd_valid;
    logic [17:0] rw_resp;
    logic        rw_resp_valid;

    modport slave (
        input  host_cmd, host_cmd_valid,
        output host_cmd_ready, host_resp, host_resp_valid,
        input  init_cmd, init_cmd_valid,
        output init_cmd_ready, init_resp, init_resp_valid,
        output rw_cmd, rw_cmd_valid,
        input  rw_resp, rw_resp_valid
    );

    modport master (
        output host_cmd, host_cmd_valid,
        input  host_cmd_ready, host_resp, host_resp_valid,
        output init_cmd, init_cmd_valid,
        input  init_cmd_ready, init_resp, init_resp_valid,
        input  rw_cmd, rw_cmd_valid,
        output rw_resp, rw_resp_valid
    );
endinterface

// File: rtl/cam_cmd_arbiter.sv
// Round-robin arbiter for the camera register channel: one command in
// flight, response routed back to its issuer, timeout on a silent engine.
module cam_cmd_arbiter #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_W           = 16
) (
    input  logic                fclk,
    input  logic                rst,
    cam_cmd_arbiter_if.slave    bus,
    output logic                busy,
    output logic                owner,
    output logic [15:0]         timeout_cnt,
    output logic [15:0]         stray_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [17:0]     TO_RESP   = 18'h3FFFF;

    state_t          state;
    logic            last_grant;
    logic [TO_W-1:0] wait_cnt;
    logic            host_go;
    logic            init_go;
    logic            wait_done;
    logic [17:0]     resp_data;

    // Tie goes to whichever requester was not served last.
    always_comb begin
        host_go = 1'b0;
        init_go = 1'b0;
        if (state == IDLE) begin
            host_go = bus.host_cmd_valid &&
                      (!bus.init_cmd_valid || last_grant);
            init_go = bus.init_cmd_valid &&
                      (!bus.host_cmd_valid || !last_grant);
        end
    end

    assign bus.host_cmd_ready = host_go;
    assign bus.init_cmd_ready = init_go;
    assign busy               = (state != IDLE);

    // A real response on the last wait cycle beats the timeout.
    assign wait_done = bus.rw_resp_valid || (wait_cnt == WAIT_LAST);
    assign resp_data = bus.rw_resp_valid ? bus.rw_resp : TO_RESP;

    always_ff @(posedge fclk) begin
        if (rst) begin
            state               <= IDLE;
            last_grant          <= 1'b0;
            wait_cnt            <= '0;
            owner               <= 1'b0;
            timeout_cnt         <= 16'd0;
            stray_cnt           <= 16'd0;
            bus.rw_cmd          <= 17'd0;
            bus.rw_cmd_valid    <= 1'b0;
            bus.host_resp       <= 18'd0;
            bus.host_resp_valid <= 1'b0;
            bus.init_resp       <= 18'd0;
            bus.init_resp_valid <= 1'b0;
        end else begin
            bus.rw_cmd_valid    <= 1'b0;
            bus.host_resp_valid <= 1'b0;
            bus.init_resp_valid <= 1'b0;

            if (bus.rw_resp_valid && state != WAIT &&
                stray_cnt != 16'hFFFF) begin
                stray_cnt <= stray_cnt + 16'd1;
            end

            unique case (state)
                IDLE: begin
                    if (host_go || init_go) begin
                        bus.rw_cmd       <= init_go ? bus.init_cmd
                                                    : bus.host_cmd;
                        bus.rw_cmd_valid <= 1'b1;
                        owner            <= init_go;
                        last_grant       <= init_go;
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_done) begin
                        if (owner) begin
                            bus.init_resp       <= resp_data;
                            bus.init_resp_valid <= 1'b1;
                        end else begin
                            bus.host_resp       <= resp_data;
                            bus.host_resp_valid <= 1'b1;
                        end
                        if (!bus.rw_resp_valid &&
                            timeout_cnt != 16'hFFFF) begin
                            timeout_cnt <= timeout_cnt + 16'd1;
                        end
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
